// File: rtl/mem_req_arbiter.sv
// mem_req_fifo: small synchronous FIFO with a registered not-full flag and a fall-through head.
// Latency: a pushed entry is visible at dout on the cycle after the push edge.
// Backpressure: rdy_q is low while full (and during reset); callers never push when full or pop when empty.
module mem_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             rdy_q
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rdy_d;

    // Pointer/count update; ready is derived from the next count so it is exact yet registered.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        rdy_d    = (cnt_d != CW'(DEPTH));
    end

    // Control state; ready stays low while reset is held and rises on the first clock after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rdy_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rdy_q    <= rdy_d;
        end
    end

    // Storage array; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (cnt_q == '0);

endmodule

// mem_req_arbiter: per-port request queues, round-robin onto one memory port, in-order read return routing.
// Latency: request accepted at edge E0 appears on mem_valid after E1; read data returns on rsp one cycle after mem_rvalid.
// Backpressure: req_ready drops when a port queue is full; reads stall (writes pass) while OUTST reads are outstanding.
module mem_req_arbiter #(
    parameter int NPORT  = 4,
    parameter int ADDR_W = 27,
    parameter int DATA_W = 128,
    parameter int QDEPTH = 4,
    parameter int OUTST  = 8
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic [NPORT-1:0]         req_valid,
    input  logic [NPORT-1:0]         req_we,
    input  logic [NPORT*ADDR_W-1:0]  req_addr,
    input  logic [NPORT*DATA_W-1:0]  req_wdata,
    output logic [NPORT-1:0]         req_ready,
    output logic                     mem_valid,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic                     mem_ready,
    input  logic                     mem_rvalid,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [NPORT-1:0]         rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     busy,
    output logic                     err
);

    localparam int PW = $clog2(NPORT);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    localparam int RW = $bits(req_t);

    // Per-port queues
    req_t             q_din  [NPORT];
    req_t             q_dout [NPORT];
    logic [NPORT-1:0] q_push;
    logic [NPORT-1:0] q_pop;
    logic [NPORT-1:0] q_empty;
    logic [NPORT-1:0] q_rdy;
    logic [NPORT-1:0] elig;

    // Tag FIFO of outstanding read owners
    logic             tag_push;
    logic             tag_pop;
    logic [PW-1:0]    tag_head;
    logic             tag_empty;
    logic             tag_rdy;

    // Arbitration
    logic             can_load;
    logic             gnt_vld;
    logic [PW-1:0]    gnt_idx;
    logic [PW:0]      cand;
    req_t             gnt_req;

    // Registered state
    logic [PW-1:0]    p_q, p_d;
    logic             out_vld_q, out_vld_d;
    req_t             out_q, out_d;
    logic [NPORT-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic             err_q, err_d;

    for (genvar k = 0; k < NPORT; k++) begin : g_port
        assign q_din[k] = '{we:    req_we[k],
                            addr:  req_addr[k*ADDR_W +: ADDR_W],
                            wdata: req_wdata[k*DATA_W +: DATA_W]};
        assign q_push[k] = req_valid[k] & q_rdy[k];

        mem_req_fifo #(
            .WIDTH (RW),
            .DEPTH (QDEPTH)
        ) u_q (
            .clk   (sys_clk),
            .rst   (rst),
            .push  (q_push[k]),
            .din   (q_din[k]),
            .pop   (q_pop[k]),
            .dout  (q_dout[k]),
            .empty (q_empty[k]),
            .rdy_q (q_rdy[k])
        );

        // A read head waits for a free tag slot; a write head never does.
        assign elig[k] = ~q_empty[k] & (q_dout[k].we | tag_rdy);
    end

    assign req_ready = q_rdy;

    mem_req_fifo #(
        .WIDTH (PW),
        .DEPTH (OUTST)
    ) u_tag (
        .clk   (sys_clk),
        .rst   (rst),
        .push  (tag_push),
        .din   (gnt_idx),
        .pop   (tag_pop),
        .dout  (tag_head),
        .empty (tag_empty),
        .rdy_q (tag_rdy)
    );

    // Round-robin search from p over eligible heads, only when the output register can take a new entry.
    always_comb begin
        can_load = ~out_vld_q | mem_ready;
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        cand     = '0;
        if (can_load) begin
            for (int i = 0; i < NPORT; i++) begin
                cand = {1'b0, p_q} + (PW+1)'(i);
                if (cand >= (PW+1)'(NPORT)) begin
                    cand = cand - (PW+1)'(NPORT);
                end
                if (!gnt_vld && elig[cand[PW-1:0]]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand[PW-1:0];
                end
            end
        end
    end

    // Grant side effects: pop the winner, load the output register, advance p, record read owner.
    always_comb begin
        q_pop     = '0;
        gnt_req   = q_dout[gnt_idx];
        tag_push  = 1'b0;
        p_d       = p_q;
        out_vld_d = out_vld_q & ~mem_ready;
        out_d     = out_q;
        if (gnt_vld) begin
            q_pop[gnt_idx] = 1'b1;
            tag_push       = ~gnt_req.we;
            p_d            = (gnt_idx == PW'(NPORT-1)) ? '0 : gnt_idx + 1'b1;
            out_vld_d      = 1'b1;
            out_d          = gnt_req;
        end
    end

    // Read return: route to the oldest tag; data with no tag outstanding is dropped and flagged.
    always_comb begin
        tag_pop     = mem_rvalid & ~tag_empty;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        err_d       = err_q;
        if (tag_pop) begin
            rsp_valid_d[tag_head] = 1'b1;
            rsp_data_d            = mem_rdata;
        end
        if (mem_rvalid && tag_empty) begin
            err_d = 1'b1;
        end
    end

    // Arbiter pointer, output register, response register and sticky error.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            p_q         <= '0;
            out_vld_q   <= 1'b0;
            out_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            p_q         <= p_d;
            out_vld_q   <= out_vld_d;
            out_q       <= out_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
        end
    end

    assign mem_valid = out_vld_q;
    assign mem_we    = out_q.we;
    assign mem_addr  = out_q.addr;
    assign mem_wdata = out_q.wdata;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign err       = err_q;
    assign busy      = ~(&q_empty) | out_vld_q | ~tag_empty;

endmodule
